cache_miss_ctrl: RTL and testbench

- Request-sequencing controller directly upstream of the 2-way, 8-set, 8-bit-data cache; sole driver of the cache's addr/wren/data_in.
- Accepts one processor request at a time, probes the cache, and on a read miss fetches the byte from main memory and fills the cache.
- All writes go through to main memory.
- Keeps saturating hit/miss counters for performance measurement.

---
 rtl/cache_miss_ctrl_if.sv | 26 ++
 rtl/cache_miss_ctrl.sv | 137 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_ctrl_if.sv
// Processor-side request/response bus of the cache miss controller.
// The processor is the master; the controller is the slave.
interface cache_miss_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wren;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wren, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wren, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_hit, resp_err
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Sequences one processor request at a time through the cache: probe, read-miss
// fill from main memory, write-through, with saturating hit/miss counters.
module cache_miss_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    cache_miss_ctrl_if.slave  req_if,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_wren,
    output logic [DATA_W-1:0] c_data_in,
    input  logic              c_hit,
    input  logic [DATA_W-1:0] c_data_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_COMPARE = 3'd2;
    localparam logic [2:0] S_CWRITE  = 3'd3;
    localparam logic [2:0] S_MEM_RD  = 3'd4;
    localparam logic [2:0] S_FILL    = 3'd5;
    localparam logic [2:0] S_MEM_WR  = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    // The wait counter starts at 0 in the first memory cycle, so the last
    // permitted waiting cycle is the one where it equals MEM_TIMEOUT-1.
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic              wren_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              hit_q;
    logic              err_q;
    logic [15:0]       timer_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        addr_q  <= req_if.req_addr;
                        wren_q  <= req_if.req_wren;
                        wdata_q <= req_if.req_wdata;
                        data_q  <= '0;
                        hit_q   <= 1'b0;
                        err_q   <= 1'b0;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= S_COMPARE;
                S_COMPARE: begin
                    hit_q   <= c_hit;
                    timer_q <= '0;
                    if (c_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    end
                    if (wren_q) begin
                        state <= S_CWRITE;
                    end else if (c_hit) begin
                        data_q <= c_data_out;
                        state  <= S_RESP;
                    end else begin
                        state <= S_MEM_RD;
                    end
                end
                S_CWRITE: begin
                    timer_q <= '0;
                    state   <= S_MEM_WR;
                end
                // An ack arriving in the final permitted cycle takes priority over the timeout.
                S_MEM_RD, S_MEM_WR: begin
                    if (mem_ack) begin
                        if (state == S_MEM_RD) begin
                            data_q <= mem_rdata;
                            state  <= S_FILL;
                        end else begin
                            state <= S_RESP;
                        end
                    end else if (timer_q == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_FILL:  state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_if.req_ready  = (state == S_IDLE);
        req_if.resp_valid = (state == S_RESP);
        req_if.resp_hit   = (state == S_RESP) && hit_q;
        req_if.resp_err   = (state == S_RESP) && err_q;
        req_if.resp_rdata = '0;
        if (state == S_RESP && !wren_q && !err_q) req_if.resp_rdata = data_q;

        c_addr    = (state == S_IDLE) ? '0 : addr_q;
        c_wren    = (state == S_CWRITE) || (state == S_FILL);
        c_data_in = '0;
        if (state == S_CWRITE) c_data_in = wdata_q;
        if (state == S_FILL)   c_data_in = data_q;

        mem_rd    = (state == S_MEM_RD);
        mem_wr    = (state == S_MEM_WR);
        mem_addr  = (mem_rd || mem_wr) ? addr_q : '0;
        mem_wdata = mem_wr ? wdata_q : '0;
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: a 2-way 8-set cache model, a memory
// responder with programmable ack delay, and a request-level reference model.
module tb_cache_miss_ctrl;
   localparam int TMO  = 8;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;
   localparam int NEVER = 99;

   logic clock;
   logic reset;
   logic [4:0] c_addr;
   logic c_wren;
   logic [7:0] c_data_in;
   logic c_hit;
   logic [7:0] c_data_out;
   logic [4:0] mem_addr;
   logic mem_rd;
   logic mem_wr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic mem_ack;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   logic ackResp;
   logic strayAck;
   int ackDelay;
   logic cacheClear;
   logic [7:0] mem [32];

   logic [4:0] expCAddr;
   logic [4:0] expMAddr;
   logic [7:0] expMWdata;
   logic [7:0] expCData;
   logic expIsWrite;

   int hitModel;
   int missModel;
   int checks;
   int errors;

   int wrenPulses;
   int memCycles;
   int busBad;
   int respPulses;

   cache_miss_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   cache_miss_ctrl #(
      .ADDR_W(5), .DATA_W(8), .MEM_TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset), .req_if(bus),
      .c_addr(c_addr), .c_wren(c_wren), .c_data_in(c_data_in),
      .c_hit(c_hit), .c_data_out(c_data_out),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   assign mem_ack = ackResp | strayAck;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cache model: registered address, combinational lookup, writes on the edge
   // that ends a c_wren cycle, round-robin victim per set on allocation.
   logic cValid [2][8];
   logic [1:0] cTag [2][8];
   logic [7:0] cData [2][8];
   logic cVictim [8];
   logic [4:0] cAddrQ;

   always @(posedge clock) begin
      cAddrQ <= c_addr;
      if (cacheClear) begin
         for (int s = 0; s < 8; s++) begin
            cValid[0][s] <= 1'b0;
            cValid[1][s] <= 1'b0;
            cVictim[s] <= 1'b0;
         end
      end else if (c_wren) begin
         if (cValid[0][c_addr[2:0]] && cTag[0][c_addr[2:0]] == c_addr[4:3])
            cData[0][c_addr[2:0]] <= c_data_in;
         else if (cValid[1][c_addr[2:0]] && cTag[1][c_addr[2:0]] == c_addr[4:3])
            cData[1][c_addr[2:0]] <= c_data_in;
         else begin
            cValid[cVictim[c_addr[2:0]]][c_addr[2:0]] <= 1'b1;
            cTag[cVictim[c_addr[2:0]]][c_addr[2:0]] <= c_addr[4:3];
            cData[cVictim[c_addr[2:0]]][c_addr[2:0]] <= c_data_in;
            cVictim[c_addr[2:0]] <= ~cVictim[c_addr[2:0]];
         end
      end
   end

   always_comb begin
      c_hit = 1'b0;
      c_data_out = 8'h00;
      for (int w = 0; w < 2; w++) begin
         if (cValid[w][cAddrQ[2:0]] && cTag[w][cAddrQ[2:0]] == cAddrQ[4:3]) begin
            c_hit = 1'b1;
            c_data_out = cData[w][cAddrQ[2:0]];
         end
      end
   end

   // Memory responder: acks a held mem_rd/mem_wr after ackDelay extra cycles,
   // and abandons the request if the controller drops it first.
   initial begin
      bit aborted;
      ackResp = 1'b0;
      mem_rdata = 8'h00;
      for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
      mem[5'h13] = 8'hA5;
      forever begin
         @(negedge clock);
         if (mem_rd || mem_wr) begin
            aborted = 1'b0;
            for (int k = 0; k < ackDelay; k++) begin
               @(negedge clock);
               if (!(mem_rd || mem_wr)) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               mem_rdata = mem[mem_addr];
               if (mem_wr) mem[mem_addr] = mem_wdata;
               ackResp = 1'b1;
               @(posedge clock);
               #1;
               ackResp = 1'b0;
               mem_rdata = 8'h00;
            end
         end
      end
   end

   // Bus monitor: counts fill/write pulses, memory request cycles and responses,
   // and flags any cycle where the cache or memory bus carries the wrong values.
   always @(negedge clock) begin
      int bad;
      bad = 0;
      if (c_wren && c_data_in != expCData) bad++;
      if (bus.req_ready && c_addr != 5'h00) bad++;
      if (!bus.req_ready && c_addr != expCAddr) bad++;
      if (mem_rd && mem_wr) bad++;
      if ((mem_rd || mem_wr) && mem_addr != expMAddr) bad++;
      if (mem_wr && mem_wdata != expMWdata) bad++;
      if (mem_rd && expIsWrite) bad++;
      if (mem_wr && !expIsWrite) bad++;
      if (!bus.resp_valid && (bus.resp_hit || bus.resp_err || bus.resp_rdata != 8'h00)) bad++;
      busBad <= busBad + bad;
      if (c_wren) wrenPulses <= wrenPulses + 1;
      if (mem_rd || mem_wr) memCycles <= memCycles + 1;
      if (bus.resp_valid) respPulses <= respPulses + 1;
   end

   initial begin
      wrenPulses = 0;
      memCycles = 0;
      busBad = 0;
      respPulses = 0;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cacheLookup(input logic [4:0] a, output logic h, output logic [7:0] d);
      h = 1'b0;
      d = 8'h00;
      for (int w = 0; w < 2; w++) begin
         if (cValid[w][a[2:0]] && cTag[w][a[2:0]] == a[4:3]) begin
            h = 1'b1;
            d = cData[w][a[2:0]];
         end
      end
   endtask

   // Issues one request, predicts its outcome from the cache/memory contents and
   // the chosen ack delay, and checks response, latency, bus activity and counters.
   task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                                input int d, input logic stray,
                                output logic gHit, output logic [7:0] gRd, output logic gErr);
      logic mHit;
      logic [7:0] mData;
      logic eErr;
      logic [7:0] eRd;
      int eLat, eWren, eMem, lat, guard, w0, m0, b0;
      cacheLookup(a, mHit, mData);
      eErr = (wr || !mHit) && (d >= TMO);
      eRd = (wr || eErr) ? 8'h00 : (mHit ? mData : mem[a]);
      if (!wr && mHit) eLat = 3;
      else if (eErr) eLat = (wr ? 4 : 3) + TMO;
      else eLat = 5 + d;
      eWren = (!wr && mHit) ? 0 : ((!wr && eErr) ? 0 : 1);
      eMem = (!wr && mHit) ? 0 : (eErr ? TMO : d + 1);
      if (mHit) hitModel = (hitModel == MAXC) ? MAXC : hitModel + 1;
      else missModel = (missModel == MAXC) ? MAXC : missModel + 1;
      expCAddr = a;
      expMAddr = a;
      expMWdata = wd;
      expCData = wr ? wd : mem[a];
      expIsWrite = wr;
      ackDelay = d;
      strayAck = stray && !wr && mHit;

      @(negedge clock);
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      checkOutput("ready_before_req", bus.req_ready, 1);
      w0 = wrenPulses;
      m0 = memCycles;
      b0 = busBad;
      bus.req_valid = 1'b1;
      bus.req_addr = a;
      bus.req_wren = wr;
      bus.req_wdata = wd;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr = 5'h1F;
      bus.req_wdata = 8'hEE;
      checkOutput("busy_after_accept", bus.req_ready, 0);
      lat = 1;
      while (!bus.resp_valid && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checkOutput("resp_seen", bus.resp_valid, 1);
      checkOutput("latency", lat, eLat);
      gHit = bus.resp_hit;
      gRd = bus.resp_rdata;
      gErr = bus.resp_err;
      checkOutput("resp_hit", gHit, mHit);
      checkOutput("resp_rdata", gRd, eRd);
      checkOutput("resp_err", gErr, eErr);
      checkOutput("hit_count", hit_count, hitModel);
      checkOutput("miss_count", miss_count, missModel);
      @(posedge clock);
      #1;
      strayAck = 1'b0;
      checkOutput("resp_one_cycle", bus.resp_valid, 0);
      checkOutput("ready_after_resp", bus.req_ready, 1);
      checkOutput("c_wren_pulses", wrenPulses - w0, eWren);
      checkOutput("mem_req_cycles", memCycles - m0, eMem);
      checkOutput("bus_values", busBad - b0, 0);
   endtask

   task automatic pulseReset();
      @(negedge clock);
      reset = 1'b1;
      hitModel = 0;
      missModel = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic resetMidRead();
      int guard, r0;
      ackDelay = NEVER;
      strayAck = 1'b0;
      expCAddr = 5'h0A;
      expMAddr = 5'h0A;
      expMWdata = 8'h00;
      expCData = 8'h00;
      expIsWrite = 1'b0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_addr = 5'h0A;
      bus.req_wren = 1'b0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      guard = 0;
      while (!mem_rd && guard < 20) begin
         @(posedge clock);
         #1;
         guard++;
      end
      checkOutput("rst_reached_mem_rd", mem_rd, 1);
      checkOutput("rst_miss_before", miss_count, 1);
      r0 = respPulses;
      #2;
      reset = 1'b1;
      hitModel = 0;
      missModel = 0;
      #1;
      checkOutput("rst_mem_rd_drop", mem_rd, 0);
      checkOutput("rst_ready", bus.req_ready, 1);
      checkOutput("rst_hit_count", hit_count, 0);
      checkOutput("rst_miss_count", miss_count, 0);
      checkOutput("rst_resp_valid", bus.resp_valid, 0);
      checkOutput("rst_c_addr", c_addr, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("rst_no_resp", respPulses - r0, 0);
      checkOutput("rst_no_fill", c_wren, 0);
   endtask

   typedef struct {
      logic wren;
      logic [4:0] addr;
      logic [7:0] wdata;
      int delay;
      logic stray;
      logic expHit;
      logic [7:0] expRdata;
      logic expErr;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   initial begin
      logic gH, gE;
      logic [7:0] gR;
      vecs[0]  = '{1'b0, 5'h13, 8'h00, 3,     1'b0, 1'b0, 8'hA5, 1'b0};
      vecs[1]  = '{1'b0, 5'h13, 8'h00, 0,     1'b0, 1'b1, 8'hA5, 1'b0};
      vecs[2]  = '{1'b1, 5'h07, 8'h3C, 2,     1'b0, 1'b0, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 5'h07, 8'h00, 0,     1'b0, 1'b1, 8'h3C, 1'b0};
      vecs[4]  = '{1'b0, 5'h0B, 8'h00, NEVER, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[5]  = '{1'b0, 5'h13, 8'h00, 0,     1'b1, 1'b1, 8'hA5, 1'b0};
      vecs[6]  = '{1'b0, 5'h0B, 8'h00, 7,     1'b0, 1'b0, 8'h4B, 1'b0};
      vecs[7]  = '{1'b0, 5'h0B, 8'h00, 0,     1'b0, 1'b1, 8'h4B, 1'b0};
      vecs[8]  = '{1'b1, 5'h1B, 8'h5A, 8,     1'b0, 1'b0, 8'h00, 1'b1};
      vecs[9]  = '{1'b0, 5'h1B, 8'h00, 0,     1'b0, 1'b1, 8'h5A, 1'b0};
      vecs[10] = '{1'b0, 5'h13, 8'h00, 0,     1'b0, 1'b0, 8'hA5, 1'b0};

      checks = 0;
      errors = 0;
      hitModel = 0;
      missModel = 0;
      strayAck = 1'b0;
      ackDelay = 0;
      expCAddr = 5'h00;
      expMAddr = 5'h00;
      expMWdata = 8'h00;
      expCData = 8'h00;
      expIsWrite = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr = 5'h00;
      bus.req_wren = 1'b0;
      bus.req_wdata = 8'h00;
      reset = 1'b1;
      cacheClear = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("init_ready", bus.req_ready, 1);
      checkOutput("init_resp_valid", bus.resp_valid, 0);
      checkOutput("init_mem_rd", mem_rd, 0);
      checkOutput("init_c_wren", c_wren, 0);
      checkOutput("init_hit_count", hit_count, 0);
      checkOutput("init_miss_count", miss_count, 0);
      @(negedge clock);
      reset = 1'b0;
      cacheClear = 1'b0;

      resetMidRead();

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].wren, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                       vecs[i].stray, gH, gR, gE);
         checkOutput($sformatf("vec%0d_hit", i), gH, vecs[i].expHit);
         checkOutput($sformatf("vec%0d_rdata", i), gR, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d_err", i), gE, vecs[i].expErr);
      end

      pulseReset();
      checkOutput("sat_start_hit", hit_count, 0);
      applyStimulus(1'b0, 5'h02, 8'h00, 1, 1'b0, gH, gR, gE);
      checkOutput("sat_fill_data", gR, 8'h42);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 5'h02, 8'h00, 0, 1'b0, gH, gR, gE);
      checkOutput("sat_hit_count", hit_count, 2'b11);
      checkOutput("sat_miss_count", miss_count, 2'b01);

      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                       8'($urandom_range(0, 255)), $urandom_range(0, 9),
                       $urandom_range(0, 3) == 0, gH, gR, gE);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
